// File: rtl/rsp_pkg.sv
// Shared constants for the result-byte return path.
// Byte lane width, pad value and default geometry.
package rsp_pkg;
    localparam int LANE_W = 8;
    localparam logic [LANE_W-1:0] PAD_BYTE = 8'h00;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_WORDS_PER_PKT = 3;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/rsp_if.sv
// Byte-in / word-out handshake bundle of the packer.
// master = harness side, slave = packer side.
interface rsp_if
    import rsp_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int CNT_W = DEF_CNT_W
);
    logic                            in_valid_i;
    logic [LANE_W-1:0]               in_data_i;
    logic                            in_ready_o;
    logic                            flush_i;
    logic                            out_valid_o;
    logic [BYTES_PER_WORD*LANE_W-1:0] out_data_o;
    logic                            out_last_o;
    logic                            out_ready_i;
    logic [CNT_W-1:0]                pkt_cnt_o;

    modport slave (
        input  in_valid_i, in_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o,
        output out_last_o, pkt_cnt_o
    );

    modport master (
        output in_valid_i, in_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o,
        input  out_last_o, pkt_cnt_o
    );
endinterface

// File: rtl/rsp_out_stage.sv
// Single-entry output holding register with valid/ready and last.
// A load wins over a same-cycle drain so words can stream at full rate.
module rsp_out_stage #(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic              last_o
);
    logic              valid_q;
    logic [WORD_W-1:0] data_q;
    logic              last_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
endmodule

// File: rtl/rsp_packer.sv
// Packs result bytes little-endian into words grouped into packets.
// Flush pads a partial word; a busy output parks it in ST_FLUSH.
module rsp_packer
    import rsp_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int WORDS_PER_PKT = DEF_WORDS_PER_PKT,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk_i,
    input logic reset_ni,
    rsp_if.slave bus
);
    localparam int WORD_W = BYTES_PER_WORD * LANE_W;
    localparam int BC_W = $clog2(BYTES_PER_WORD);
    localparam int WC_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(WORDS_PER_PKT - 1);

    typedef enum logic {ST_FILL, ST_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d, held;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d, acc_pad, ld_data;
    logic [CNT_W-1:0]  pkt_cnt_q;
    logic              out_valid, out_last, out_free;
    logic              accept, word_done, flush_req, flush_hit;
    logic              flush_emit, load, ld_last;
    logic [WORD_W-1:0] out_data;

    assign out_free = !out_valid || bus.out_ready_i;
    assign bus.in_ready_o = (state_q == ST_FILL)
                         && ((byte_cnt_q != BC_MAX) || out_free);
    assign accept    = bus.in_valid_i && bus.in_ready_o;
    assign word_done = accept && (byte_cnt_q == BC_MAX);
    assign flush_req = bus.flush_i || (state_q == ST_FLUSH);
    assign ld_last   = (word_cnt_q == WC_MAX);

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (accept && byte_cnt_q == BC_W'(k))
                acc_d[k*LANE_W +: LANE_W] = bus.in_data_i;
        end
        held = accept ? byte_cnt_q + BC_W'(1) : byte_cnt_q;
        acc_pad = acc_d;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (BC_W'(k) >= held)
                acc_pad[k*LANE_W +: LANE_W] = PAD_BYTE;
        end
        // held is only meaningful when the byte did not finish the word
        flush_hit  = flush_req && !word_done && (held != '0);
        flush_emit = flush_hit && out_free;
        load       = word_done || flush_emit;
        ld_data    = flush_emit ? acc_pad : acc_d;
        state_d    = (flush_hit && !out_free) ? ST_FLUSH : ST_FILL;
        byte_cnt_d = load ? '0 : held;
        word_cnt_d = word_cnt_q;
        if (load)
            word_cnt_d = ld_last ? '0 : word_cnt_q + WC_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_FILL;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            acc_q      <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            acc_q      <= load ? '0 : acc_d;
            if (out_valid && bus.out_ready_i && out_last)
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
        end
    end

    rsp_out_stage #(.WORD_W(WORD_W)) u_out (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .load_i  (load),
        .data_i  (ld_data),
        .last_i  (ld_last),
        .ready_i (bus.out_ready_i),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last)
    );

    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign bus.out_last_o  = out_last;
    assign bus.pkt_cnt_o   = pkt_cnt_q;
endmodule

// File: tb/tb_rsp_packer.sv
// Directed bench for rsp_packer (4 bytes/word, 3 words/packet).
// Words are logged at the falling edge preceding their handshake.
module tb_rsp_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [32:0] q[$];
    bit   watch_rdy = 1'b0;
    bit   rdy_low = 1'b0;

    rsp_if #(.BYTES_PER_WORD(4), .CNT_W(16)) bus ();

    rsp_packer #(
        .BYTES_PER_WORD(4),
        .WORDS_PER_PKT(3),
        .CNT_W(16)
    ) u_dut (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i)
            q.push_back({bus.out_last_o, bus.out_data_o});
        if (watch_rdy && bus.in_valid_i && !bus.in_ready_o)
            rdy_low = 1'b1;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int idx,
                         input logic [32:0] exp);
        logic [32:0] got;
        got = (idx < q.size()) ? q[idx] : '1;
        check(tag, 64'(got), 64'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fl);
        bit done;
        done = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = b;
        bus.flush_i    = fl;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
        end
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_flush();
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
    endtask

    task automatic reset_chk(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid_o), 64'd0);
        check({tag, "_data"}, 64'(bus.out_data_o), 64'd0);
        check({tag, "_last"}, 64'(bus.out_last_o), 64'd0);
        check({tag, "_pkt"}, 64'(bus.pkt_cnt_o), 64'd0);
        check({tag, "_rdy"}, 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 8'h00;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;

        // T0: power-on reset state
        reset_chk("rst0");

        // T1: full packet at full rate
        watch_rdy = 1'b1;
        for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b0);
        watch_rdy = 1'b0;
        idle(2);
        check("t1_cnt", 64'(q.size()), 64'd3);
        chk_q("t1_w0", 0, {1'b0, 32'h04030201});
        chk_q("t1_w1", 1, {1'b0, 32'h08070605});
        chk_q("t1_w2", 2, {1'b1, 32'h0C0B0A09});
        check("t1_pkt", 64'(bus.pkt_cnt_o), 64'd1);
        check("t1_rdylow", 64'(rdy_low), 64'd0);

        // T2: backpressure stalls the 8th byte
        q.delete();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'h11 + 8'(i), 1'b0);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h18;
        @(negedge clk);
        check("t2_stall", 64'(bus.in_ready_o), 64'd0);
        check("t2_hold", 64'(bus.out_data_o), 64'h14131211);
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("t2_go", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        idle(3);
        check("t2_cnt", 64'(q.size()), 64'd2);
        chk_q("t2_w0", 0, {1'b0, 32'h14131211});
        chk_q("t2_w1", 1, {1'b0, 32'h18171615});
        check("t2_pkt", 64'(bus.pkt_cnt_o), 64'd1);

        // T3: flush of a two-byte partial word
        reset_chk("rst3");
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        pulse_flush();
        for (int i = 0; i < 4; i++) send_byte(8'hC1 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hD1 + 8'(i), 1'b0);
        idle(2);
        check("t3_cnt", 64'(q.size()), 64'd3);
        chk_q("t3_w0", 0, {1'b0, 32'h0000BBAA});
        chk_q("t3_w1", 1, {1'b0, 32'hC4C3C2C1});
        chk_q("t3_w2", 2, {1'b1, 32'hD4D3D2D1});
        check("t3_pkt", 64'(bus.pkt_cnt_o), 64'd1);

        // T4: flush while the output register is occupied
        reset_chk("rst4");
        bus.out_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
        pulse_flush();
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h07;
        @(negedge clk);
        check("t4_pend0", 64'(bus.in_ready_o), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_pend1", 64'(bus.in_ready_o), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        for (int i = 7; i <= 10; i++) send_byte(8'(i), 1'b0);
        idle(2);
        check("t4_cnt", 64'(q.size()), 64'd3);
        chk_q("t4_w0", 0, {1'b0, 32'h04030201});
        chk_q("t4_w1", 1, {1'b0, 32'h00000605});
        chk_q("t4_w2", 2, {1'b1, 32'h0A090807});
        check("t4_pkt", 64'(bus.pkt_cnt_o), 64'd1);

        // T6: reset mid-word discards the partial bytes
        for (int i = 0; i < 6; i++) send_byte(8'h31 + 8'(i), 1'b0);
        reset_chk("rst6");
        for (int i = 0; i < 12; i++) send_byte(8'h21 + 8'(i), 1'b0);
        idle(2);
        check("t6_cnt", 64'(q.size()), 64'd3);
        chk_q("t6_w0", 0, {1'b0, 32'h24232221});
        chk_q("t6_w1", 1, {1'b0, 32'h28272625});
        chk_q("t6_w2", 2, {1'b1, 32'h2C2B2A29});
        check("t6_pkt", 64'(bus.pkt_cnt_o), 64'd1);

        // T5: flush together with the word-completing byte
        reset_chk("rst5");
        for (int i = 0; i < 3; i++) send_byte(8'hE1 + 8'(i), 1'b0);
        send_byte(8'hE4, 1'b1);
        idle(3);
        check("t5_cnt", 64'(q.size()), 64'd1);
        chk_q("t5_w0", 0, {1'b0, 32'hE4E3E2E1});
        check("t5_valid", 64'(bus.out_valid_o), 64'd0);
        check("t5_rdy", 64'(bus.in_ready_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/rsp_packer.md
# rsp_packer

Return-path packer for the DPI test harness: collects the 8-bit result bytes the BFM produces and packs them into wide words grouped into fixed-size packets, which the host side drains over a valid/ready interface. It is the counterpart of the stimulus path, which unpacks a host-generated multi-word packet into per-cycle operands. It sits between the BFM result output and the DPI export/collection logic in the wrapper.

## Interface

Parameters:
- BYTES_PER_WORD, 4, bytes packed per output word (≥2)
- WORDS_PER_PKT, 3, words per packet (≥1)
- CNT_W, 16, width of packet counter

Ports:
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous, active-low reset
- in_valid_i  input  1  result byte valid
- in_data_i  input  8  result byte
- in_ready_o  output  1  byte accepted when in_valid_i && in_ready_o
- flush_i  input  1  single-cycle request: pad and emit the partial word
- out_valid_o  output  1  output word valid
- out_data_o  output  BYTES_PER_WORD*8  packed word
- out_last_o  output  1  word is the last of a packet
- out_ready_i  input  1  consumer accepts word when out_valid_o && out_ready_i
- pkt_cnt_o  output  CNT_W  completed packets drained

## Operation

- Accumulator plus byte index byte_cnt (0..BYTES_PER_WORD-1), word index word_cnt (0..WORDS_PER_PKT-1), one output holding register.
- Byte order little-endian: first accepted byte lands in bits [7:0], byte k in [8k+7:8k].
- On acceptance with byte_cnt < BYTES_PER_WORD-1: store byte, byte_cnt++.
- On acceptance of the final byte of a word: the completed word moves into the holding register at that edge; byte_cnt←0; out_last_o←(word_cnt==WORDS_PER_PKT-1); word_cnt increments, wrapping to 0.
- in_ready_o = (byte_cnt != BYTES_PER_WORD-1) || !out_valid_o || out_ready_i. No byte is ever dropped.
- Holding register clears out_valid_o on handshake unless reloaded in the same cycle (back-to-back words at full rate).
- pkt_cnt_o increments on handshake of a word with out_last_o=1; wraps modulo 2^CNT_W.
- Flush: if byte_cnt==0 after any same-cycle byte acceptance, flush is ignored. Otherwise, unused bytes are filled with PAD_BYTE and the word is emitted as if completed (last/word_cnt rules unchanged). If the holding register is busy, a flush_pend flag holds the request, input is stalled (in_ready_o=0) until emission, and the flag then clears.
- Same-cycle flush and byte: byte is accepted first, then the flush applies; if that byte completed the word, the flush has no further effect.

## Timing

- Reset (async assert, sync-released logic): out_valid_o=0, out_data_o=0, out_last_o=0, pkt_cnt_o=0, in_ready_o=1, all counters and flush_pend 0.
- Latency: a word-completing byte accepted at edge k gives out_valid_o=1 from edge k to the handshake; a flush at edge k with free output gives valid after edge k.
- Throughput: one byte per cycle sustained with out_ready_i=1.
- out_data_o/out_last_o are stable while out_valid_o=1 and not accepted.
- Reset mid-word or mid-packet discards partial data; the next byte starts at byte 0 of word 0.

## Structure

- Package rsp_pkg: PAD_BYTE = 8'h00, default parameter values, byte-lane width constant.
- One sub-module: rsp_out_stage (holding register with valid/ready and last). The packer FSM and counters live in rsp_packer.

## Test plan

(Defaults: BYTES_PER_WORD=4, WORDS_PER_PKT=3.)
- Stream bytes 01..0C back-to-back, out_ready_i=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09 (last=1), pkt_cnt_o=1, in_ready_o never low.
- out_ready_i=0, offer 8 bytes -> first word held; in_ready_o low while 8th byte pending; release ready -> both words emitted in order, nothing lost.
- Bytes AA, BB then flush_i -> word 0x0000BBAA, last=0; the next bytes start a new word as word 1.
- Flush while output busy -> in_ready_o=0 until drain; padded word emitted after the held word.
- Flush in the same cycle as the 4th byte -> exactly one word, no extra padded word.
- Assert reset_ni low after 6 bytes -> outputs take reset values; the next 12 bytes form one clean packet.
